// File: rtl/play_ctrl_pkg.sv
// Shared types for the playback controller: FSM state codes, command encoding,
// pending-slot record and volume saturation helpers.
package play_ctrl_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_PLAY     = 2'd0;
    localparam state_t ST_PAUSE    = 2'd1;
    localparam state_t ST_SWITCH   = 2'd2;
    localparam state_t ST_WAIT_RDY = 2'd3;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_NEXT,
        CMD_PREV,
        CMD_PAUSE_TOG,
        CMD_SELECT
    } cmd_t;

    typedef struct packed {
        cmd_t       cmd;
        logic [4:0] song;
    } slot_t;

    localparam logic [7:0] VOL_MIN = 8'h00;
    localparam logic [7:0] VOL_MAX = 8'hFE;

    // One attenuation byte; louder lowers attenuation.
    function automatic logic [7:0] vol_adjust(input logic [7:0] level,
                                              input logic [7:0] step,
                                              input logic       louder);
        logic [8:0] sum;
        sum = {1'b0, level} + {1'b0, step};
        if (louder)
            vol_adjust = (level >= step) ? level - step : VOL_MIN;
        else
            vol_adjust = (sum > {1'b0, VOL_MAX}) ? VOL_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/play_ctrl_arbiter_if.sv
// Command/status bundle between the input sources, the MP3 decoder and the
// playback controller.
interface play_ctrl_arbiter_if;

    logic        i_btn_next;
    logic        i_btn_pre;
    logic        i_btn_pause;
    logic        i_btn_vol_up;
    logic        i_btn_vol_dn;
    logic        i_bt_next;
    logic        i_bt_pre;
    logic        i_bt_pause;
    logic [15:0] i_bt_vol;
    logic        i_bt_vol_vld;
    logic [4:0]  i_bt_song;
    logic        i_bt_song_vld;
    logic        i_FINISH;
    logic        i_dec_ready;
    logic [4:0]  o_song;
    logic [15:0] o_vol;
    logic        o_pause;
    logic        o_dec_rst;
    logic        o_busy;

    modport master (
        output i_btn_next, i_btn_pre, i_btn_pause, i_btn_vol_up, i_btn_vol_dn,
        output i_bt_next, i_bt_pre, i_bt_pause, i_bt_vol, i_bt_vol_vld,
        output i_bt_song, i_bt_song_vld, i_FINISH, i_dec_ready,
        input  o_song, o_vol, o_pause, o_dec_rst, o_busy
    );

    modport slave (
        input  i_btn_next, i_btn_pre, i_btn_pause, i_btn_vol_up, i_btn_vol_dn,
        input  i_bt_next, i_bt_pre, i_bt_pause, i_bt_vol, i_bt_vol_vld,
        input  i_bt_song, i_bt_song_vld, i_FINISH, i_dec_ready,
        output o_song, o_vol, o_pause, o_dec_rst, o_busy
    );

endinterface

// File: rtl/play_cmd_slot.sv
// One-deep pending command register; a write overwrites (latest wins) and
// takes precedence over a same-cycle read-and-clear.
module play_cmd_slot
    import play_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en,
    input  slot_t wr_data,
    input  logic  rd_clr,
    output logic  valid,
    output slot_t rd_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            rd_data <= '0;
        end else if (wr_en) begin
            valid   <= 1'b1;
            rd_data <= wr_data;
        end else if (rd_clr) begin
            valid   <= 1'b0;
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/play_ctrl_arbiter.sv
// Playback controller: arbitrates button/bluetooth/end-of-song commands and
// sequences decoder restarts. Define PLAY_CTRL_SHUFFLE_EN for shuffled auto-advance.
module play_ctrl_arbiter
    import play_ctrl_pkg::*;
#(
    parameter int unsigned SONG_NUM    = 2,
    parameter logic [7:0]  VOL_STEP    = 8'h10,
    parameter logic [15:0] VOL_DEFAULT = 16'h2020,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned READY_TMO   = 1000
)
(
    input logic                clk,
    input logic                rst_n,
    play_ctrl_arbiter_if.slave bus
);

    localparam int unsigned     CNT_MAX    = (READY_TMO > RST_CYCLES) ? READY_TMO : RST_CYCLES;
    localparam int unsigned     CNT_W      = $clog2(CNT_MAX) + 1;
    localparam logic [4:0]      LAST_SONG  = 5'(SONG_NUM - 1);
    localparam logic [5:0]      SONG_LIMIT = 6'(SONG_NUM);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(READY_TMO - 1);

    state_t           state, state_nxt;
    logic [4:0]       song, song_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      vol, vol_nxt;

    slot_t btn_cmd, bt_cmd, auto_cmd, win;
    slot_t btn_slot, bt_slot;
    logic  btn_slot_vld, bt_slot_vld;
    logic  btn_wr, bt_wr, btn_clr, bt_clr;
    logic  go_switch;

    always_comb begin
        btn_cmd = '0;
        if (bus.i_btn_next)       btn_cmd.cmd = CMD_NEXT;
        else if (bus.i_btn_pre)   btn_cmd.cmd = CMD_PREV;
        else if (bus.i_btn_pause) btn_cmd.cmd = CMD_PAUSE_TOG;

        bt_cmd = '0;
        if (bus.i_bt_song_vld) begin
            bt_cmd.cmd  = CMD_SELECT;
            bt_cmd.song = bus.i_bt_song;
        end else if (bus.i_bt_next)  bt_cmd.cmd = CMD_NEXT;
        else if (bus.i_bt_pre)       bt_cmd.cmd = CMD_PREV;
        else if (bus.i_bt_pause)     bt_cmd.cmd = CMD_PAUSE_TOG;
    end

`ifdef PLAY_CTRL_SHUFFLE_EN
    logic [7:0] lfsr;
    logic [4:0] shuf_pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'h5A;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_comb begin
        shuf_pick = 5'(32'(lfsr) % SONG_NUM);
        if (shuf_pick == song)
            shuf_pick = (song == LAST_SONG) ? '0 : song + 5'd1;
        auto_cmd.cmd  = CMD_SELECT;
        auto_cmd.song = shuf_pick;
    end
`else
    always_comb begin
        auto_cmd.cmd  = CMD_NEXT;
        auto_cmd.song = '0;
    end
`endif

    // Pending slots hold older commands, so they beat everything live; any
    // live command that loses is parked in its own source's slot.
    always_comb begin
        win     = '0;
        btn_clr = 1'b0;
        bt_clr  = 1'b0;
        btn_wr  = (btn_cmd.cmd != CMD_NONE);
        bt_wr   = (bt_cmd.cmd != CMD_NONE);
        if (state == ST_PLAY || state == ST_PAUSE) begin
            if (btn_slot_vld) begin
                win     = btn_slot;
                btn_clr = 1'b1;
            end else if (bt_slot_vld) begin
                win    = bt_slot;
                bt_clr = 1'b1;
            end else if (bus.i_FINISH && state == ST_PLAY) begin
                win = auto_cmd;
            end else if (btn_wr) begin
                win    = btn_cmd;
                btn_wr = 1'b0;
            end else if (bt_wr) begin
                win   = bt_cmd;
                bt_wr = 1'b0;
            end
        end
    end

    play_cmd_slot u_btn_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (btn_wr),
        .wr_data (btn_cmd),
        .rd_clr  (btn_clr),
        .valid   (btn_slot_vld),
        .rd_data (btn_slot)
    );

    play_cmd_slot u_bt_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bt_wr),
        .wr_data (bt_cmd),
        .rd_clr  (bt_clr),
        .valid   (bt_slot_vld),
        .rd_data (bt_slot)
    );

    always_comb begin
        state_nxt = state;
        song_nxt  = song;
        cnt_nxt   = cnt;
        go_switch = 1'b0;
        case (state)
            ST_PLAY, ST_PAUSE: begin
                case (win.cmd)
                    CMD_NEXT: begin
                        song_nxt  = (song == LAST_SONG) ? '0 : song + 5'd1;
                        go_switch = 1'b1;
                    end
                    CMD_PREV: begin
                        song_nxt  = (song == '0) ? LAST_SONG : song - 5'd1;
                        go_switch = 1'b1;
                    end
                    CMD_SELECT: begin
                        if ({1'b0, win.song} < SONG_LIMIT) begin
                            song_nxt  = win.song;
                            go_switch = 1'b1;
                        end
                    end
                    CMD_PAUSE_TOG: state_nxt = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                    default: ;
                endcase
                if (go_switch) begin
                    state_nxt = ST_SWITCH;
                    cnt_nxt   = '0;
                end
            end
            ST_SWITCH: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_RDY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (bus.i_dec_ready) begin
                    state_nxt = ST_PLAY;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = ST_SWITCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        vol_nxt = vol;
        if (bus.i_btn_vol_up)
            vol_nxt = {vol_adjust(vol[15:8], VOL_STEP, 1'b1), vol_adjust(vol[7:0], VOL_STEP, 1'b1)};
        else if (bus.i_btn_vol_dn)
            vol_nxt = {vol_adjust(vol[15:8], VOL_STEP, 1'b0), vol_adjust(vol[7:0], VOL_STEP, 1'b0)};
        else if (bus.i_bt_vol_vld)
            vol_nxt = bus.i_bt_vol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PLAY;
            song  <= '0;
            cnt   <= '0;
            vol   <= VOL_DEFAULT;
        end else begin
            state <= state_nxt;
            song  <= song_nxt;
            cnt   <= cnt_nxt;
            vol   <= vol_nxt;
        end
    end

    assign bus.o_song    = song;
    assign bus.o_vol     = vol;
    assign bus.o_pause   = (state == ST_PAUSE);
    assign bus.o_dec_rst = (state == ST_SWITCH);
    assign bus.o_busy    = (state == ST_SWITCH) || (state == ST_WAIT_RDY);

endmodule
